// File: rtl/arb8_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package arb8_pkg;
    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int HOLD_MAX_DEF = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;
endpackage : arb8_pkg

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arb8_if;
    import arb8_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (output req, input gnt, input gnt_idx, input gnt_valid, input timeout);
    modport slave  (input req, output gnt, output gnt_idx, output gnt_valid, output timeout);
endinterface : rr_arb8_if

// File: rtl/rr_arb8_onehot_enc8.sv
// Combinational 8-bit one-hot to 3-bit binary index encoder (all-zero in gives 0).
module onehot_enc8
    import arb8_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx
);
    // OR together the indices of set bits; exact for one-hot or zero input.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = idx | (onehot[i] ? 3'(i) : 3'd0);
        end
    end
endmodule : onehot_enc8

// File: rtl/rr_arb8.sv
// 8-way round-robin arbiter with one-cycle release bubble.
// Optional hold timeout and per-requester mask enabled by macro ARB8_TIMEOUT_EN.
module rr_arb8
    import arb8_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    rr_arb8_if.slave   bus
);
    localparam logic [7:0] HOLD_MAX_W = 8'(HOLD_MAX);

    arb_state_e       state_r, state_nxt_s;
    logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
    logic [N_REQ-1:0] gnt_r, gnt_nxt_s;
    logic             gnt_valid_r;
    logic             timeout_r, timeout_nxt_s;
    logic [IDX_W-1:0] gnt_idx_s;
    logic [N_REQ-1:0] eligible_s;
    logic [IDX_W-1:0] win_idx_s;
    logic [IDX_W-1:0] cand_s;
    logic             win_found_s;

`ifdef ARB8_TIMEOUT_EN
    logic [7:0]       hold_cnt_r, hold_cnt_nxt_s;
    logic [N_REQ-1:0] mask_r, mask_nxt_s;
    assign eligible_s = bus.req & ~mask_r;
`else
    logic unused_hold_s;
    assign unused_hold_s = ^HOLD_MAX_W;
    assign eligible_s    = bus.req;
`endif

    onehot_enc8 u_enc (
        .onehot (gnt_r),
        .idx    (gnt_idx_s)
    );

    // Winner search from ptr upward; scanning downward lets the nearest candidate win last.
    always_comb begin
        win_idx_s   = 3'd0;
        cand_s      = 3'd0;
        win_found_s = |eligible_s;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_s    = ptr_r + 3'(k);
            win_idx_s = eligible_s[cand_s] ? cand_s : win_idx_s;
        end
    end

    // Next-state, grant, pointer and (optionally) hold/mask logic.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        gnt_nxt_s     = gnt_r;
        timeout_nxt_s = 1'b0;
`ifdef ARB8_TIMEOUT_EN
        hold_cnt_nxt_s = hold_cnt_r;
        mask_nxt_s     = mask_r & bus.req;
`endif
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    gnt_nxt_s   = 8'd1 << win_idx_s;
                    state_nxt_s = ST_GRANT;
`ifdef ARB8_TIMEOUT_EN
                    hold_cnt_nxt_s = 8'd0;
`endif
                end else begin
                    gnt_nxt_s = 8'd0;
                end
            end
            ST_GRANT: begin
                if (!bus.req[gnt_idx_s]) begin
                    gnt_nxt_s   = 8'd0;
                    ptr_nxt_s   = gnt_idx_s + 3'd1;
                    state_nxt_s = ST_IDLE;
`ifdef ARB8_TIMEOUT_EN
                end else if (hold_cnt_r == (HOLD_MAX_W - 8'd1)) begin
                    gnt_nxt_s               = 8'd0;
                    ptr_nxt_s               = gnt_idx_s + 3'd1;
                    state_nxt_s             = ST_IDLE;
                    timeout_nxt_s           = 1'b1;
                    mask_nxt_s[gnt_idx_s]   = 1'b1;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + 8'd1;
                end
`else
                end else begin
                    gnt_nxt_s = gnt_r;
                end
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 3'd0;
            gnt_r       <= 8'd0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
`ifdef ARB8_TIMEOUT_EN
            hold_cnt_r  <= 8'd0;
            mask_r      <= 8'd0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_valid_r <= |gnt_nxt_s;
            timeout_r   <= timeout_nxt_s;
`ifdef ARB8_TIMEOUT_EN
            hold_cnt_r  <= hold_cnt_nxt_s;
            mask_r      <= mask_nxt_s;
`endif
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_idx   = gnt_idx_s;
    assign bus.gnt_valid = gnt_valid_r;
`ifdef ARB8_TIMEOUT_EN
    assign bus.timeout   = timeout_r;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule : rr_arb8

// File: tb/tb_rr_arb8.sv
// Directed self-checking bench for rr_arb8; the timeout scenario runs when ARB8_TIMEOUT_EN is defined.
module tb_rr_arb8;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rr_arb8_if bus ();

`ifdef ARB8_TIMEOUT_EN
    rr_arb8 #(.HOLD_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    rr_arb8 dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset gnt=%h idx=%0d valid=%b to=%b exp 00/0/0/0", bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.gnt, bus.gnt_idx, bus.gnt_valid} !== {8'h00, 3'd0, 1'b0}) begin
                errors++;
                $display("FAIL idle_no_req cyc=%0d gnt=%h idx=%0d valid=%b exp 00/0/0", i, bus.gnt, bus.gnt_idx, bus.gnt_valid);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_gnt [6] = '{8'h01, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00};
        logic [2:0] exp_idx [6] = '{3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0};
        logic [7:0] req_seq [6] = '{8'h81, 8'h80, 8'h80, 8'h00, 8'h81, 8'h00};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.req = req_seq[i];
            tick();
            checks++;
            if ({bus.gnt, bus.gnt_idx, bus.gnt_valid} !== {exp_gnt[i], exp_idx[i], (exp_gnt[i] != 8'h00)}) begin
                errors++;
                $display("FAIL wrap step=%0d gnt=%h idx=%0d valid=%b exp %h/%0d", i, bus.gnt, bus.gnt_idx, bus.gnt_valid, exp_gnt[i], exp_idx[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_gnt;
        do_reset();
        bus.req = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            exp_gnt = 8'd1 << i;
            tick();
            checks++;
            if ({bus.gnt, bus.gnt_idx, bus.gnt_valid} !== {exp_gnt, 3'(i), 1'b1}) begin
                errors++;
                $display("FAIL sweep_grant i=%0d gnt=%h idx=%0d exp %h/%0d", i, bus.gnt, bus.gnt_idx, exp_gnt, i);
            end
            bus.req = 8'hFF & ~exp_gnt;
            tick();
            checks++;
            if ({bus.gnt, bus.gnt_valid} !== {8'h00, 1'b0}) begin
                errors++;
                $display("FAIL sweep_bubble i=%0d gnt=%h valid=%b exp 00/0", i, bus.gnt, bus.gnt_valid);
            end
            bus.req = 8'hFF;
        end
        bus.req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.req = 8'h08;
        tick();
        checks++;
        if ({bus.gnt, bus.gnt_idx} !== {8'h08, 3'd3}) begin
            errors++;
            $display("FAIL mid_pre gnt=%h idx=%0d exp 08/3", bus.gnt, bus.gnt_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset gnt=%h idx=%0d valid=%b exp 00/0/0", bus.gnt, bus.gnt_idx, bus.gnt_valid);
        end
        tick();
        checks++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_valid} !== {8'h08, 3'd3, 1'b1}) begin
            errors++;
            $display("FAIL mid_regrant gnt=%h idx=%0d exp 08/3", bus.gnt, bus.gnt_idx);
        end
        bus.req = 8'h00;
        tick();
        tick();
    endtask

`ifdef ARB8_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] exp_gnt [12] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00};
        logic       exp_to  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        bus.req = 8'h06;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({bus.gnt, bus.timeout} !== {exp_gnt[i], exp_to[i]}) begin
                errors++;
                $display("FAIL timeout step=%0d gnt=%h to=%b exp %h/%b", i, bus.gnt, bus.timeout, exp_gnt[i], exp_to[i]);
            end
        end
        bus.req = 8'h04;
        tick();
        bus.req = 8'h06;
        tick();
        checks++;
        if ({bus.gnt, bus.gnt_idx, bus.timeout} !== {8'h02, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL unmask_regrant gnt=%h idx=%0d to=%b exp 02/1/0", bus.gnt, bus.gnt_idx, bus.timeout);
        end
        bus.req = 8'h00;
        tick();
        tick();
    endtask
`else
    task automatic test_hold_forever();
        do_reset();
        bus.req = 8'h01;
        for (int i = 0; i < 300; i++) begin
            tick();
            checks++;
            if ({bus.gnt, bus.gnt_valid, bus.timeout} !== {8'h01, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL hold cyc=%0d gnt=%h valid=%b to=%b exp 01/1/0", i, bus.gnt, bus.gnt_valid, bus.timeout);
            end
        end
        bus.req = 8'h00;
        tick();
    endtask
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.req = 8'h00;
        test_reset();
        test_wrap();
        test_back_to_back();
        test_reset_mid_grant();
`ifdef ARB8_TIMEOUT_EN
        test_timeout();
`else
        test_hold_forever();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_rr_arb8
